// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the DIV/DIVU controller.
package div_ctrl_pkg;

  localparam int DIV_RESULT_WD = 64;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on a 65-bit {remainder, quotient} word.
module div_step (
  input  logic [64:0] pr_in,
  input  logic [31:0] divisor,
  output logic [64:0] pr_out
);

  logic [64:0] sh;
  logic [33:0] diff;
  logic        unused_msb;

  // The top bit never carries information: the remainder is always below the divisor.
  assign unused_msb = pr_in[64];
  assign sh         = {pr_in[63:0], 1'b0};
  assign diff       = {1'b0, sh[64:32]} - {2'b00, divisor};
  assign pr_out     = diff[33] ? sh : {diff[32:0], pr_in[30:0], 1'b1};

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller: 32 restoring iterations, result held until start_i drops.
// Define DIV_SIGNED_EN to honour signed_i; otherwise every division is unsigned.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start_i,
  input  logic                     signed_i,
  input  logic [31:0]              opdata1_i,
  input  logic [31:0]              opdata2_i,
  input  logic                     annul_i,
  output logic [DIV_RESULT_WD-1:0] result_o,
  output logic                     ready_o,
  output logic                     stallreq_o
);

  div_state_e               state, state_nxt;
  logic [5:0]               cnt;
  logic [64:0]              pr, pr_nxt;
  logic [31:0]              dvsr;
  logic [DIV_RESULT_WD-1:0] res_q;
  logic [31:0]              op1_abs, op2_abs;
  logic [31:0]              quo, rem;
  logic                     accept, zero_div, last_step, load;

  assign accept    = start_i && !annul_i;
  assign zero_div  = (opdata2_i == 32'd0);
  assign last_step = (cnt == 6'd31);
  assign load      = (state == DIV_FREE) && accept && !zero_div;

  div_step u_step (
    .pr_in   (pr),
    .divisor (dvsr),
    .pr_out  (pr_nxt)
  );

`ifdef DIV_SIGNED_EN
  logic sgn1, sgn2, sgn1_q, sgn2_q;

  assign sgn1    = signed_i & opdata1_i[31];
  assign sgn2    = signed_i & opdata2_i[31];
  assign op1_abs = sgn1 ? neg32(opdata1_i) : opdata1_i;
  assign op2_abs = sgn2 ? neg32(opdata2_i) : opdata2_i;
  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  assign quo     = (sgn1_q ^ sgn2_q) ? neg32(pr_nxt[31:0]) : pr_nxt[31:0];
  assign rem     = sgn1_q ? neg32(pr_nxt[63:32]) : pr_nxt[63:32];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sgn1_q <= 1'b0;
      sgn2_q <= 1'b0;
    end else if (load) begin
      sgn1_q <= sgn1;
      sgn2_q <= sgn2;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign op1_abs       = opdata1_i;
  assign op2_abs       = opdata2_i;
  assign quo           = pr_nxt[31:0];
  assign rem           = pr_nxt[63:32];
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= DIV_FREE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DIV_FREE:    if (accept) state_nxt = zero_div ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: state_nxt = annul_i ? DIV_FREE : DIV_END;
      DIV_ON: begin
        if (annul_i)        state_nxt = DIV_FREE;
        else if (last_step) state_nxt = DIV_END;
      end
      DIV_END:     if (annul_i || !start_i) state_nxt = DIV_FREE;
      default:     state_nxt = DIV_FREE;
    endcase
  end

  always_comb begin
    ready_o    = (state == DIV_END);
    result_o   = ready_o ? res_q : '0;
    stallreq_o = start_i & (state != DIV_END);
  end

  // Datapath: operand capture, iteration, and result capture on entry to END.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= 6'd0;
      pr    <= '0;
      dvsr  <= '0;
      res_q <= '0;
    end else begin
      case (state)
        DIV_FREE: if (load) begin
          cnt  <= 6'd0;
          pr   <= {33'd0, op1_abs};
          dvsr <= op2_abs;
        end
        DIV_BY_ZERO: res_q <= '0;
        DIV_ON: begin
          pr  <= pr_nxt;
          cnt <= cnt + 6'd1;
          if (last_step) res_q <= {rem, quo};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table plus annul, reset, hold and operand-change sequences.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn, start_i, signed_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [63:0] exp, input int lat, input int hold, input string name);
    int cyc;
    int stalls;
    @(posedge clk); #1;
    opdata1_i = a; opdata2_i = b; signed_i = sgn; start_i = 1'b1;
    cyc = 0; stalls = 0;
    while (cyc < 40) begin
      @(negedge clk);
      if (ready_o) break;
      if (stallreq_o) stalls++;
      cyc++;
    end
    check({name, " latency"}, cyc, lat);
    check({name, " result"}, result_o, exp);
    check({name, " stall cycles"}, stalls, lat);
    check({name, " stall at ready"}, stallreq_o, 1'b0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, " hold ready"}, ready_o, 1'b1);
      check({name, " hold result"}, result_o, exp);
    end
    @(posedge clk); #1;
    start_i = 1'b0; opdata1_i = 32'hA5A5A5A5; opdata2_i = 32'h0;
    @(negedge clk);
    check({name, " drop still ready"}, ready_o, 1'b1);
    @(negedge clk);
    check({name, " idle ready"}, ready_o, 1'b0);
    check({name, " idle result"}, result_o, 64'h0);
  endtask

  task automatic count_ready(input int n, input string name);
    int readies;
    readies = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ready_o) readies++;
    end
    check(name, readies, 0);
  endtask

  initial begin
    int cyc;
    tbl[0]  = '{32'd100,      32'd7,        1'b0, 64'h00000002_0000000E, 33};
    tbl[1]  = '{32'h12345678, 32'd0,        1'b0, 64'h0,                 2};
    tbl[2]  = '{32'hFFFFFFFF, 32'd0,        1'b1, 64'h0,                 2};
    tbl[3]  = '{32'd5,        32'd10,       1'b0, 64'h00000005_00000000, 33};
    tbl[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001, 33};
    tbl[5]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 33};
    tbl[6]  = '{32'hFFFFFFFE, 32'h80000001, 1'b0, 64'h7FFFFFFD_00000001, 33};
    tbl[7]  = '{32'd100,      32'd7,        1'b1, 64'h00000002_0000000E, 33};
    tbl[8]  = '{32'h80000000, 32'd1,        1'b1, 64'h00000000_80000000, 33};
    tbl[9]  = '{32'd9,        32'd3,        1'b0, 64'h00000000_00000003, 33};
`ifdef DIV_SIGNED_EN
    tbl[10] = '{32'hFFFFFFF9, 32'd2,        1'b1, 64'hFFFFFFFF_FFFFFFFD, 33};
    tbl[11] = '{32'd7,        32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33};
    tbl[12] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, 33};
`else
    tbl[10] = '{32'hFFFFFFF9, 32'd2,        1'b1, 64'h00000001_7FFFFFFC, 33};
    tbl[11] = '{32'd7,        32'hFFFFFFFE, 1'b1, 64'h00000007_00000000, 33};
    tbl[12] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFF9C_00000000, 33};
`endif
    tbl[13] = '{32'hFFFFFFF9, 32'd2,        1'b0, 64'h00000001_7FFFFFFC, 33};

    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = 32'h0; opdata2_i = 32'h0;
    #12;
    check("reset ready", ready_o, 1'b0);
    check("reset result", result_o, 64'h0);
    check("reset stall", stallreq_o, 1'b0);
    start_i = 1'b1;
    #1 check("reset stall follows start", stallreq_o, 1'b1);
    start_i = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++)
      do_div(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].exp, tbl[i].lat, 0, $sformatf("vec%0d", i));

    do_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 5, "hold5");

    // Annul at cycle 10 of ON, then annul blocking acceptance in IDLE
    @(posedge clk); #1;
    opdata1_i = 32'd1234; opdata2_i = 32'd5; signed_i = 1'b0; start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 annul_i = 1'b1;
    @(negedge clk);
    check("annul cycle10 ready", ready_o, 1'b0);
    check("annul cycle10 stall", stallreq_o, 1'b1);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("annul cycle11 stall", stallreq_o, 1'b0);
    count_ready(40, "annul no ready");
    @(posedge clk); #1;
    annul_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    check("annul idle stall", stallreq_o, 1'b1);
    repeat (3) @(posedge clk);
    #1 annul_i = 1'b0; start_i = 1'b0;
    count_ready(40, "annul idle blocked");
    do_div(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, 0, "after annul");

    // Annul while holding in END
    @(posedge clk); #1;
    opdata1_i = 32'd20; opdata2_i = 32'd4; start_i = 1'b1;
    cyc = 0;
    while (cyc < 40 && !ready_o) begin
      @(negedge clk);
      cyc++;
    end
    check("end annul reached", ready_o, 1'b1);
    @(posedge clk); #1 annul_i = 1'b1;
    @(negedge clk);
    check("end annul pre ready", ready_o, 1'b1);
    @(negedge clk);
    check("end annul idle ready", ready_o, 1'b0);
    check("end annul idle result", result_o, 64'h0);
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;

    // Asynchronous reset in cycle 15 of ON
    @(posedge clk); #1;
    opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (15) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rst on ready", ready_o, 1'b0);
    check("rst on result", result_o, 64'h0);
    check("rst on stall", stallreq_o, 1'b1);
    start_i = 1'b0;
    #1 check("rst on stall low", stallreq_o, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    do_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 0, "after reset");

    // Operands change and start drops mid-division
    @(posedge clk); #1;
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    opdata1_i = 32'h0000FFFF; opdata2_i = 32'd3;
    repeat (4) @(posedge clk);
    #1 start_i = 1'b0; opdata2_i = 32'h0;
    @(negedge clk);
    check("drop stall low", stallreq_o, 1'b0);
    cyc = 5;
    while (cyc < 45 && !ready_o) begin
      @(negedge clk);
      cyc++;
    end
    check("drop latency", cyc, 33);
    check("drop result", result_o, 64'h00000002_0000000E);
    @(negedge clk);
    check("drop idle ready", ready_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
